// File: rtl/mux_4_1_rr_arbiter_if.sv
// Handshake bundle for the 4:1 round-robin arbiter: four requester valid/ready/data lanes and one output channel.
// The master modport is the arbiter's view and the slave modport is the surrounding producers' and consumer's view.
interface mux_4_1_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    modport master (
        input  in_valid, d0, d1, d2, d3, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        output in_valid, d0, d1, d2, d3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin 4:1 arbiter/mux; MUX_ARB_BURST_EN adds a burst lock of up to MAX_BURST beats per owner.
// Latency: 1 cycle from transfer to out_*; 1 beat/cycle throughput.
// Backpressure: the output slot loads only when empty or accepted; all state holds otherwise.
module mux_4_1_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_4_1_rr_arbiter_if.master bus
);
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 1");
    end

    logic             load_en;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [1:0]       search_ptr;
    logic             xfer;
    logic [WIDTH-1:0] grant_dat;

    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;

`ifdef MUX_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_new;
    logic          hold;
    logic          lock_drop;
`endif

    // Grant selection: a live lock wins, otherwise search from ptr (or from owner+1 when the owner just dropped).
    always_comb begin
        load_en = !out_valid_q || bus.out_ready;
`ifdef MUX_ARB_BURST_EN
        hold       = (state_q == LOCKED) && bus.in_valid[owner_q] && (cnt_q < CW'(MAX_BURST));
        lock_drop  = (state_q == LOCKED) && !bus.in_valid[owner_q];
        search_ptr = lock_drop ? owner_q + 2'd1 : ptr_q;
`else
        search_ptr = ptr_q;
`endif
        grant_vld = 1'b0;
        grant_idx = search_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.in_valid[search_ptr + 2'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = search_ptr + 2'(k);
            end
        end
`ifdef MUX_ARB_BURST_EN
        if (hold) begin
            grant_vld = 1'b1;
            grant_idx = owner_q;
        end
`endif
        xfer = load_en && grant_vld;
        case (grant_idx)
            2'd0:    grant_dat = bus.d0;
            2'd1:    grant_dat = bus.d1;
            2'd2:    grant_dat = bus.d2;
            default: grant_dat = bus.d3;
        endcase
    end

    // Next state
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifdef MUX_ARB_BURST_EN
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_new = cnt_q;
`endif
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_dat;
                out_sel_d  = grant_idx;
            end
`ifdef MUX_ARB_BURST_EN
            if (lock_drop) begin
                state_d = IDLE;
                ptr_d   = owner_q + 2'd1;
            end
            if (xfer) begin
                if ((state_q == LOCKED) && (grant_idx == owner_q)) begin
                    cnt_new = cnt_q + CW'(1);
                end else begin
                    cnt_new = CW'(1);
                end
                owner_d = grant_idx;
                cnt_d   = cnt_new;
                state_d = LOCKED;
                if (cnt_new == CW'(MAX_BURST)) begin
                    state_d = IDLE;
                    ptr_d   = grant_idx + 2'd1;
                end
            end
`else
            if (xfer) begin
                ptr_d = grant_idx + 2'd1;
            end
`endif
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
`ifdef MUX_ARB_BURST_EN
            state_q <= IDLE;
            owner_q <= 2'd0;
            cnt_q   <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef MUX_ARB_BURST_EN
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs; ready is forced low while reset is held.
    always_comb begin
        bus.in_ready  = (rst_n && xfer) ? (4'b0001 << grant_idx) : 4'b0000;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_sel   = out_sel_q;
    end
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for mux_4_1_rr_arbiter: a behavioural arbitration model checked on every falling edge,
// plus directed phases with literal expectations (reset, rotation, single requester, stall, owner drop, idle).
module tb_mux_4_1_rr_arbiter;
    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    mux_4_1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_4_1_rr_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dval(input int i);
        case (i)
            0:       return int'(bus.d0);
            1:       return int'(bus.d1);
            2:       return int'(bus.d2);
            default: return int'(bus.d3);
        endcase
    endfunction

    // Model state: output slot contents plus arbitration bookkeeping.
    int m_ov = 0, m_od = 0, m_os = 0, m_ptr = 0;
    int n_ov = 0, n_od = 0, n_os = 0, n_ptr = 0;
`ifdef MUX_ARB_BURST_EN
    int m_locked = 0, m_owner = 0, m_cnt = 0;
    int n_locked = 0, n_owner = 0, n_cnt = 0;
`endif

    always @(negedge clk) begin
        int g, start, le, exp_rdy;
        int t_ov, t_od, t_os, t_ptr;
`ifdef MUX_ARB_BURST_EN
        int t_locked, t_owner, t_cnt;
        t_locked = m_locked; t_owner = m_owner; t_cnt = m_cnt;
`endif
        t_ov = m_ov; t_od = m_od; t_os = m_os; t_ptr = m_ptr;
        g = -1;
        exp_rdy = 0;
        le = (m_ov == 0 || bus.out_ready) ? 1 : 0;
        if (rst_n && le != 0) begin
            start = m_ptr;
`ifdef MUX_ARB_BURST_EN
            if (m_locked != 0 && bus.in_valid[m_owner] && m_cnt < MAX_BURST) g = m_owner;
            if (m_locked != 0 && !bus.in_valid[m_owner]) begin
                start    = (m_owner + 1) % 4;
                t_locked = 0;
                t_ptr    = start;
            end
`endif
            for (int k = 0; k < 4; k++)
                if (g < 0 && bus.in_valid[(start + k) % 4]) g = (start + k) % 4;
            t_ov = (g >= 0) ? 1 : 0;
            if (g >= 0) begin
                exp_rdy = 1 << g;
                t_od = dval(g);
                t_os = g;
`ifdef MUX_ARB_BURST_EN
                if (m_locked != 0 && g == m_owner) t_cnt = m_cnt + 1;
                else begin
                    t_owner = g;
                    t_cnt   = 1;
                end
                t_locked = 1;
                if (t_cnt == MAX_BURST) begin
                    t_locked = 0;
                    t_ptr    = (g + 1) % 4;
                end
`else
                t_ptr = (g + 1) % 4;
`endif
            end
        end
        check("cmp_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("cmp_out_valid", 32'(bus.out_valid), rst_n ? 32'(m_ov) : 32'd0);
        check("cmp_out_data", 32'(bus.out_data), rst_n ? 32'(m_od) : 32'd0);
        check("cmp_out_sel", 32'(bus.out_sel), rst_n ? 32'(m_os) : 32'd0);
        n_ov <= t_ov; n_od <= t_od; n_os <= t_os; n_ptr <= t_ptr;
`ifdef MUX_ARB_BURST_EN
        n_locked <= t_locked; n_owner <= t_owner; n_cnt <= t_cnt;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov <= 0; m_od <= 0; m_os <= 0; m_ptr <= 0;
`ifdef MUX_ARB_BURST_EN
            m_locked <= 0; m_owner <= 0; m_cnt <= 0;
`endif
        end else begin
            m_ov <= n_ov; m_od <= n_od; m_os <= n_os; m_ptr <= n_ptr;
`ifdef MUX_ARB_BURST_EN
            m_locked <= n_locked; m_owner <= n_owner; m_cnt <= n_cnt;
`endif
        end
    end

`ifdef MUX_ARB_BURST_EN
    int rot_exp[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    localparam logic [3:0] RESUME_RDY = 4'b0001;
    localparam int         RESUME_SEL = 0;
    localparam int         RESUME_DAT = 7;
`else
    int rot_exp[5] = '{0, 1, 2, 3, 0};
    localparam logic [3:0] RESUME_RDY = 4'b0010;
    localparam int         RESUME_SEL = 1;
    localparam int         RESUME_DAT = 2;
`endif

    initial begin
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        bus.d0 = 4'h1; bus.d1 = 4'h2; bus.d2 = 4'h3; bus.d3 = 4'h4;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_sel", 32'(bus.out_sel), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Fair rotation with all requesters valid
        for (int k = 0; k < $size(rot_exp); k++) begin
            @(posedge clk); @(negedge clk);
            check("rot_out_sel", 32'(bus.out_sel), 32'(rot_exp[k]));
            check("rot_out_valid", 32'(bus.out_valid), 32'd1);
        end

        // Asynchronous reset mid-traffic, then requester 0 wins first
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_out_sel", 32'(bus.out_sel), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("postrst_out_sel", 32'(bus.out_sel), 32'd0);
        check("postrst_out_valid", 32'(bus.out_valid), 32'd1);

        // Single requester: no bubble across burst boundaries
        @(posedge clk); #1 bus.in_valid = 4'b0100; bus.d2 = 4'hA;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            check("single_out_sel", 32'(bus.out_sel), 32'd2);
            check("single_out_data", 32'(bus.out_data), 32'hA);
            check("single_out_valid", 32'(bus.out_valid), 32'd1);
        end

        // Backpressure: three stalled cycles hold the beat; d0 changes underneath
        @(posedge clk); #1 rst_n = 1'b0; bus.in_valid = 4'b1111; bus.d0 = 4'h1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0; bus.d0 = 4'h7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_sel", 32'(bus.out_sel), 32'd0);
            check("stall_out_data", 32'(bus.out_data), 32'h1);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("resume_in_ready", 32'(bus.in_ready), 32'(RESUME_RDY));
        @(posedge clk); @(negedge clk);
        check("resume_out_sel", 32'(bus.out_sel), 32'(RESUME_SEL));
        check("resume_out_data", 32'(bus.out_data), 32'(RESUME_DAT));

        // Owner drop: requester 1 for two beats, then only requester 3
        @(posedge clk); #1 rst_n = 1'b0; bus.in_valid = 4'b0010;
        #2 rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1 bus.in_valid = 4'b1000;
        @(negedge clk);
        check("drop_in_ready", 32'(bus.in_ready), 32'b1000);
        check("drop_prev_sel", 32'(bus.out_sel), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) bus.in_valid = 4'b1111;
            @(negedge clk);
            check("drop_out_sel", 32'(bus.out_sel), 32'd3);
            check("drop_out_data", 32'(bus.out_data), 32'h4);
        end
        @(posedge clk); #1 bus.in_valid = 4'b0000;
        @(negedge clk);
        check("after3_out_sel", 32'(bus.out_sel), 32'd0);
        check("after3_out_valid", 32'(bus.out_valid), 32'd1);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // Idle: valid falls one cycle after the last beat, data holds
        @(posedge clk); @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_out_data", 32'(bus.out_data), 32'h7);
        check("idle_out_sel", 32'(bus.out_sel), 32'd0);
        @(posedge clk); @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
